// File: rtl/fp_alu_driver.sv
// Command-side initiator for the FP ALU start/valid_out handshake: queues tagged
// requests, issues one at a time, returns result/flags/latency and keeps sticky flags.
module fp_alu_driver #(
  parameter int FIFO_DEPTH = 4,
  parameter int LAT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_op_a,
  input  logic [31:0]      cmd_op_b,
  input  logic [2:0]       cmd_op_code,
  input  logic             cmd_mode_fp,
  input  logic             cmd_round_mode,
  input  logic [3:0]       cmd_tag,
  output logic             alu_start,
  output logic [31:0]      alu_op_a,
  output logic [31:0]      alu_op_b,
  output logic [2:0]       alu_op_code,
  output logic             alu_mode_fp,
  output logic             alu_round_mode,
  input  logic [31:0]      alu_result,
  input  logic [4:0]       alu_flags,
  input  logic             alu_valid_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [4:0]       rsp_flags,
  output logic [3:0]       rsp_tag,
  output logic [LAT_W-1:0] rsp_latency,
  output logic [4:0]       sticky_flags,
  input  logic             sticky_clr,
  output logic             busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 73;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [3:0]       tag_q, tag_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             alu_start_q, alu_start_d;
  logic [31:0]      alu_op_a_q, alu_op_a_d, alu_op_b_q, alu_op_b_d;
  logic [2:0]       alu_op_code_q, alu_op_code_d;
  logic             alu_mode_fp_q, alu_mode_fp_d, alu_round_mode_q, alu_round_mode_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_result_q, rsp_result_d;
  logic [4:0]       rsp_flags_q, rsp_flags_d;
  logic [3:0]       rsp_tag_q, rsp_tag_d;
  logic [LAT_W-1:0] rsp_latency_q, rsp_latency_d;
  logic [4:0]       sticky_q, sticky_d;

  logic             push, pop, load;
  logic [31:0]      ld_result;
  logic [4:0]       ld_flags;
  logic [3:0]       ld_tag;
  logic [LAT_W-1:0] ld_lat;

  logic [31:0] h_a, h_b;
  logic [2:0]  h_op;
  logic        h_mode, h_rm;
  logic [3:0]  h_tag;

  assign {h_a, h_b, h_op, h_mode, h_rm, h_tag} = mem_q[rd_ptr_q];

  always_comb begin
    push             = cmd_valid && cmd_ready_q;
    pop              = 1'b0;
    load             = 1'b0;
    ld_result        = 32'h0;
    ld_flags         = 5'b00000;
    ld_tag           = 4'h0;
    ld_lat           = '0;
    state_d          = state_q;
    lat_d            = lat_q;
    tag_d            = tag_q;
    alu_start_d      = alu_start_q;
    alu_op_a_d       = alu_op_a_q;
    alu_op_b_d       = alu_op_b_q;
    alu_op_code_d    = alu_op_code_q;
    alu_mode_fp_d    = alu_mode_fp_q;
    alu_round_mode_d = alu_round_mode_q;

    case (state_q)
      S_IDLE: begin
        // A lingering valid_out from the ALU must drop before a new op may start.
        if (count_q != '0 && !rsp_valid_q && !alu_valid_out) begin
          pop = 1'b1;
          if (!h_op[2]) begin
            alu_op_a_d       = h_a;
            alu_op_b_d       = h_b;
            alu_op_code_d    = h_op;
            alu_mode_fp_d    = h_mode;
            alu_round_mode_d = h_rm;
            alu_start_d      = 1'b1;
            lat_d            = LAT_W'(1);
            tag_d            = h_tag;
            state_d          = S_ISSUE;
          end else begin
            load     = 1'b1;
            ld_flags = 5'b10000;
            ld_tag   = h_tag;
          end
        end else begin
          pop = 1'b0;
        end
      end
      S_ISSUE: begin
        if (alu_valid_out) begin
          load        = 1'b1;
          ld_result   = alu_result;
          ld_flags    = alu_flags;
          ld_tag      = tag_q;
          ld_lat      = lat_q;
          alu_start_d = 1'b0;
          state_d     = S_DRAIN;
        end else if (lat_q != '1) begin
          lat_d = lat_q + LAT_W'(1);
        end else begin
          lat_d = lat_q;
        end
      end
      S_DRAIN: begin
        if (!alu_valid_out) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d     = S_IDLE;
        alu_start_d = 1'b0;
      end
    endcase

    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_latency_d = rsp_latency_q;
    if (load) begin
      rsp_valid_d   = 1'b1;
      rsp_result_d  = ld_result;
      rsp_flags_d   = ld_flags;
      rsp_tag_d     = ld_tag;
      rsp_latency_d = ld_lat;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end

    // A clear coinciding with a load keeps only the newly loaded flags.
    if (load) begin
      sticky_d = (sticky_clr ? 5'b00000 : sticky_q) | ld_flags;
    end else if (sticky_clr) begin
      sticky_d = 5'b00000;
    end else begin
      sticky_d = sticky_q;
    end

    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    cmd_ready_d = (count_d != DEPTH_C);
    busy_d      = (count_d != '0) || (state_d != S_IDLE) || rsp_valid_d;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_op_a, cmd_op_b, cmd_op_code, cmd_mode_fp, cmd_round_mode, cmd_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      state_q          <= S_IDLE;
      lat_q            <= '0;
      tag_q            <= 4'h0;
      cmd_ready_q      <= 1'b0;
      busy_q           <= 1'b0;
      alu_start_q      <= 1'b0;
      alu_op_a_q       <= 32'h0;
      alu_op_b_q       <= 32'h0;
      alu_op_code_q    <= 3'b000;
      alu_mode_fp_q    <= 1'b0;
      alu_round_mode_q <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_result_q     <= 32'h0;
      rsp_flags_q      <= 5'b00000;
      rsp_tag_q        <= 4'h0;
      rsp_latency_q    <= '0;
      sticky_q         <= 5'b00000;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      state_q          <= state_d;
      lat_q            <= lat_d;
      tag_q            <= tag_d;
      cmd_ready_q      <= cmd_ready_d;
      busy_q           <= busy_d;
      alu_start_q      <= alu_start_d;
      alu_op_a_q       <= alu_op_a_d;
      alu_op_b_q       <= alu_op_b_d;
      alu_op_code_q    <= alu_op_code_d;
      alu_mode_fp_q    <= alu_mode_fp_d;
      alu_round_mode_q <= alu_round_mode_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_result_q     <= rsp_result_d;
      rsp_flags_q      <= rsp_flags_d;
      rsp_tag_q        <= rsp_tag_d;
      rsp_latency_q    <= rsp_latency_d;
      sticky_q         <= sticky_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign alu_start      = alu_start_q;
  assign alu_op_a       = alu_op_a_q;
  assign alu_op_b       = alu_op_b_q;
  assign alu_op_code    = alu_op_code_q;
  assign alu_mode_fp    = alu_mode_fp_q;
  assign alu_round_mode = alu_round_mode_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_result     = rsp_result_q;
  assign rsp_flags      = rsp_flags_q;
  assign rsp_tag        = rsp_tag_q;
  assign rsp_latency    = rsp_latency_q;
  assign sticky_flags   = sticky_q;

endmodule
